// File: rtl/tx_arbiter_pkg.sv
// Shared types and default sizing for the TX serializer arbiter.
package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } state_e;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_GAP_CYCLES = 1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner picker: rotate requests so last+1 sits at bit 0,
// take the lowest set bit, rotate the one-hot result back.
module rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int N = DEF_N_REQ
) (
  input  logic [N-1:0]         i_Req,
  input  logic [$clog2(N)-1:0] i_Last,
  output logic [N-1:0]         o_Winner,
  output logic                 o_Valid
);

  localparam int LW = $clog2(N);

  logic [LW:0]  w_Sh;
  logic [N-1:0] w_Rot;
  logic [N-1:0] w_Pri;

  // Rotation amount is last+1; it may equal N, which is a full turn.
  assign w_Sh  = {1'b0, i_Last} + (LW+1)'(1);
  assign w_Rot = N'({i_Req, i_Req} >> w_Sh);
  // Isolate lowest set bit.
  assign w_Pri = w_Rot & (~w_Rot + N'(1));
  // Rotate back: upper half of the doubled vector shifted left.
  assign o_Winner = N'(({w_Pri, w_Pri} << w_Sh) >> N);
  assign o_Valid  = |i_Req;

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin owner of the single txshift serializer: grants one requester,
// holds its latched byte on the shifter for one frame, acks, then idles.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                    i_Pclk,
  input  logic                    i_Presetn,
  input  logic [N_REQ-1:0]        i_Req,
  input  logic [N_REQ*DATA_W-1:0] i_Data,
  output logic [N_REQ-1:0]        o_Ack,
  output logic [N_REQ-1:0]        o_Grant,
  output logic                    o_Busy,
  output logic                    o_Shift_Enable,
  output logic [DATA_W-1:0]       o_Shift_Data,
  input  logic                    i_Shift_Pready
);

  localparam int LW = $clog2(N_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e            r_State;
  logic [N_REQ-1:0]  r_Grant;
  logic [N_REQ-1:0]  r_Ack;
  logic              r_Busy;
  logic              r_En;
  logic [DATA_W-1:0] r_Data;
  logic [GW-1:0]     r_Gap;
  logic [LW-1:0]     r_Last;

  logic [N_REQ-1:0]  w_Winner;
  logic              w_Valid;
  logic [DATA_W-1:0] w_WinData;
  logic [LW-1:0]     w_GrantIdx;

  rr_pick #(.N(N_REQ)) u_pick (
    .i_Req    (i_Req),
    .i_Last   (r_Last),
    .o_Winner (w_Winner),
    .o_Valid  (w_Valid)
  );

  // Select the winner's byte from the packed data bus.
  always_comb begin
    w_WinData = '0;
    for (int k = 0; k < N_REQ; k++)
      if (w_Winner[k]) w_WinData = i_Data[DATA_W*k +: DATA_W];
  end

  // Index of the current owner, recorded as 'last' at frame completion.
  always_comb begin
    w_GrantIdx = '0;
    for (int k = 0; k < N_REQ; k++)
      if (r_Grant[k]) w_GrantIdx = LW'(k);
  end

  // Arbitration FSM with registered shifter-facing outputs.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      r_State <= IDLE;
      r_Grant <= '0;
      r_Ack   <= '0;
      r_Busy  <= 1'b0;
      r_En    <= 1'b0;
      r_Data  <= '0;
      r_Gap   <= '0;
      r_Last  <= LW'(N_REQ-1);
    end else begin
      r_Ack <= '0;
      case (r_State)
        IDLE: if (w_Valid) begin
          r_Grant <= w_Winner;
          r_Data  <= w_WinData;
          r_En    <= 1'b1;
          r_Busy  <= 1'b1;
          r_State <= SEND;
        end
        SEND: if (i_Shift_Pready) begin
          r_En    <= 1'b0;
          r_Grant <= '0;
          r_Ack   <= r_Grant;
          r_Last  <= w_GrantIdx;
          r_Gap   <= GW'(GAP_CYCLES-1);
          r_State <= GAP;
        end
        GAP: if (r_Gap == '0) begin
          r_Busy  <= 1'b0;
          r_State <= IDLE;
        end else begin
          r_Gap <= r_Gap - GW'(1);
        end
        default: r_State <= IDLE;
      endcase
    end
  end

  assign o_Grant        = r_Grant;
  assign o_Ack          = r_Ack;
  assign o_Busy         = r_Busy;
  assign o_Shift_Enable = r_En;
  assign o_Shift_Data   = r_Data;

endmodule
